// File: rtl/adam_debug_axil_obi_bridge.sv
// AXI-Lite slave to OBI master bridge for the debug subsystem slave port.
// One request register feeds OBI; an order FIFO tracks issued we bits and a
// response FIFO buffers {we,data} so B/R return strictly in issue order.
module adam_debug_axil_obi_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_TRANS  = 4,
  parameter bit          USE_RVALID = 1'b1,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    pause_req_i,
  output logic                    pause_ack_o,
  input  logic [ADDR_WIDTH-1:0]   axil_aw_addr_i,
  input  logic                    axil_aw_valid_i,
  output logic                    axil_aw_ready_o,
  input  logic [DATA_WIDTH-1:0]   axil_w_data_i,
  input  logic [DATA_WIDTH/8-1:0] axil_w_strb_i,
  input  logic                    axil_w_valid_i,
  output logic                    axil_w_ready_o,
  output logic [1:0]              axil_b_resp_o,
  output logic                    axil_b_valid_o,
  input  logic                    axil_b_ready_i,
  input  logic [ADDR_WIDTH-1:0]   axil_ar_addr_i,
  input  logic                    axil_ar_valid_i,
  output logic                    axil_ar_ready_o,
  output logic [DATA_WIDTH-1:0]   axil_r_data_o,
  output logic [1:0]              axil_r_resp_o,
  output logic                    axil_r_valid_o,
  input  logic                    axil_r_ready_i,
  output logic                    obi_req_o,
  output logic                    obi_we_o,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  input  logic                    obi_gnt_i,
  input  logic                    obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i
);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(MAX_TRANS + 1);
  localparam int unsigned PTR_W = (MAX_TRANS > 1) ? $clog2(MAX_TRANS) : 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_TRANS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // request register
  logic                  req_full_q, req_full_d, req_we_q, req_we_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [BE_W-1:0]       req_be_q, req_be_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic                  rr_q, rr_d;          // 0: write preferred
  logic                  ack_q, ack_d;
  logic [RD_LATENCY-1:0] lat_q, lat_d;
  // order FIFO (we bit per issued transaction)
  logic [MAX_TRANS-1:0]  ord_q, ord_d;
  logic [PTR_W-1:0]      ord_wp_q, ord_wp_d, ord_rp_q, ord_rp_d;
  logic [CNT_W-1:0]      ord_cnt_q, ord_cnt_d;
  // response FIFO
  logic [MAX_TRANS-1:0]                 rsp_we_q, rsp_we_d;
  logic [MAX_TRANS-1:0][DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [PTR_W-1:0]      rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
  logic [CNT_W-1:0]      rsp_cnt_q, rsp_cnt_d;

  logic             issue, reg_free, credit_ok, pick_wr, acc_wr, acc_rd;
  logic             rsp_evt, rsp_pop, head_we, b_vld, r_vld;
  logic [CNT_W:0]   total;

  // Acceptance: credit check, free request slot, round-robin W/R choice
  always_comb begin
    issue     = req_full_q & obi_gnt_i;
    reg_free  = ~req_full_q | obi_gnt_i;
    total     = (CNT_W+1)'(ord_cnt_q) + (CNT_W+1)'(rsp_cnt_q) + (CNT_W+1)'(req_full_q);
    // rst_ni gating keeps the combinational readys low during async reset
    credit_ok = rst_ni & ~pause_req_i & reg_free & (total < (CNT_W+1)'(MAX_TRANS));
    pick_wr   = axil_aw_valid_i & axil_w_valid_i & (~axil_ar_valid_i | ~rr_q);
    acc_wr    = credit_ok & pick_wr;
    acc_rd    = credit_ok & axil_ar_valid_i & ~pick_wr;
    rsp_evt   = (USE_RVALID ? obi_rvalid_i : lat_q[RD_LATENCY-1]) & (ord_cnt_q != '0);
    head_we   = rsp_we_q[rsp_rp_q];
    b_vld     = (rsp_cnt_q != '0) & head_we;
    r_vld     = (rsp_cnt_q != '0) & ~head_we;
    rsp_pop   = (b_vld & axil_b_ready_i) | (r_vld & axil_r_ready_i);
  end

  // Request register load/release, RR update and read latency line
  always_comb begin
    req_full_d  = req_full_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_be_d    = req_be_q;
    req_wdata_d = req_wdata_q;
    rr_d        = rr_q;
    lat_d       = (lat_q << 1) | RD_LATENCY'(issue);
    if (acc_wr) begin
      req_full_d  = 1'b1;
      req_we_d    = 1'b1;
      req_addr_d  = axil_aw_addr_i;
      req_be_d    = axil_w_strb_i;
      req_wdata_d = axil_w_data_i;
      rr_d        = 1'b1;
    end else if (acc_rd) begin
      req_full_d  = 1'b1;
      req_we_d    = 1'b0;
      req_addr_d  = axil_ar_addr_i;
      req_be_d    = '1;
      req_wdata_d = '0;
      rr_d        = 1'b0;
    end else if (issue) begin
      req_full_d  = 1'b0;
    end
  end

  // Order and response FIFO bookkeeping; pause ack from next-state emptiness
  always_comb begin
    ord_d      = ord_q;
    ord_wp_d   = ord_wp_q;
    ord_rp_d   = ord_rp_q;
    rsp_we_d   = rsp_we_q;
    rsp_data_d = rsp_data_q;
    rsp_wp_d   = rsp_wp_q;
    rsp_rp_d   = rsp_rp_q;
    if (issue) begin
      ord_d[ord_wp_q] = req_we_q;
      ord_wp_d        = ptr_inc(ord_wp_q);
    end
    if (rsp_evt) begin
      ord_rp_d             = ptr_inc(ord_rp_q);
      rsp_we_d[rsp_wp_q]   = ord_q[ord_rp_q];
      rsp_data_d[rsp_wp_q] = obi_rdata_i;
      rsp_wp_d             = ptr_inc(rsp_wp_q);
    end
    if (rsp_pop) rsp_rp_d = ptr_inc(rsp_rp_q);
    ord_cnt_d = ord_cnt_q + CNT_W'(issue) - CNT_W'(rsp_evt);
    rsp_cnt_d = rsp_cnt_q + CNT_W'(rsp_evt) - CNT_W'(rsp_pop);
    ack_d     = pause_req_i & ~req_full_d & (ord_cnt_d == '0) & (rsp_cnt_d == '0);
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_full_q  <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_be_q    <= '0;
      req_wdata_q <= '0;
      rr_q        <= 1'b0;
      ack_q       <= 1'b0;
      lat_q       <= '0;
      ord_q       <= '0;
      ord_wp_q    <= '0;
      ord_rp_q    <= '0;
      ord_cnt_q   <= '0;
      rsp_we_q    <= '0;
      rsp_data_q  <= '0;
      rsp_wp_q    <= '0;
      rsp_rp_q    <= '0;
      rsp_cnt_q   <= '0;
    end else begin
      req_full_q  <= req_full_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_be_q    <= req_be_d;
      req_wdata_q <= req_wdata_d;
      rr_q        <= rr_d;
      ack_q       <= ack_d;
      lat_q       <= lat_d;
      ord_q       <= ord_d;
      ord_wp_q    <= ord_wp_d;
      ord_rp_q    <= ord_rp_d;
      ord_cnt_q   <= ord_cnt_d;
      rsp_we_q    <= rsp_we_d;
      rsp_data_q  <= rsp_data_d;
      rsp_wp_q    <= rsp_wp_d;
      rsp_rp_q    <= rsp_rp_d;
      rsp_cnt_q   <= rsp_cnt_d;
    end
  end

  assign axil_aw_ready_o = acc_wr;
  assign axil_w_ready_o  = acc_wr;
  assign axil_ar_ready_o = acc_rd;
  assign axil_b_valid_o  = b_vld;
  assign axil_b_resp_o   = 2'b00;
  assign axil_r_valid_o  = r_vld;
  assign axil_r_resp_o   = 2'b00;
  assign axil_r_data_o   = r_vld ? rsp_data_q[rsp_rp_q] : '0;
  assign obi_req_o       = req_full_q;
  assign obi_we_o        = req_we_q;
  assign obi_addr_o      = req_addr_q;
  assign obi_be_o        = req_be_q;
  assign obi_wdata_o     = req_wdata_q;
  assign pause_ack_o     = ack_q;
endmodule

// File: tb/tb_adam_debug_axil_obi_bridge.sv
// Directed bench: u0 uses the fixed-latency response path, u1 uses rvalid.
module tb_adam_debug_axil_obi_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // u0 signals (USE_RVALID=0, RD_LATENCY=1)
  logic        pause0 = 0, aw_valid0 = 0, w_valid0 = 0, b_ready0 = 1, ar_valid0 = 0, r_ready0 = 1, gnt0 = 1;
  logic [31:0] aw_addr0 = '0, w_data0 = '0, ar_addr0 = '0, rdata0 = '0;
  logic [3:0]  w_strb0 = '0;
  logic        ack0, aw_ready0, w_ready0, b_valid0, ar_ready0, r_valid0, req0, we0;
  logic [1:0]  b_resp0, r_resp0;
  logic [31:0] r_data0, addr0, wdata0;
  logic [3:0]  be0;

  // u1 signals (USE_RVALID=1)
  logic        ar_valid1 = 0, r_ready1 = 1, gnt1 = 0, rvalid1 = 0;
  logic [31:0] ar_addr1 = '0, rdata1 = '0;
  logic        ack1, aw_ready1, w_ready1, b_valid1, ar_ready1, r_valid1, req1, we1;
  logic [1:0]  b_resp1, r_resp1;
  logic [31:0] r_data1, addr1, wdata1;
  logic [3:0]  be1;

  adam_debug_axil_obi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_TRANS(4),
                               .USE_RVALID(1'b0), .RD_LATENCY(1)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .pause_req_i(pause0), .pause_ack_o(ack0),
    .axil_aw_addr_i(aw_addr0), .axil_aw_valid_i(aw_valid0), .axil_aw_ready_o(aw_ready0),
    .axil_w_data_i(w_data0), .axil_w_strb_i(w_strb0), .axil_w_valid_i(w_valid0), .axil_w_ready_o(w_ready0),
    .axil_b_resp_o(b_resp0), .axil_b_valid_o(b_valid0), .axil_b_ready_i(b_ready0),
    .axil_ar_addr_i(ar_addr0), .axil_ar_valid_i(ar_valid0), .axil_ar_ready_o(ar_ready0),
    .axil_r_data_o(r_data0), .axil_r_resp_o(r_resp0), .axil_r_valid_o(r_valid0), .axil_r_ready_i(r_ready0),
    .obi_req_o(req0), .obi_we_o(we0), .obi_addr_o(addr0), .obi_be_o(be0), .obi_wdata_o(wdata0),
    .obi_gnt_i(gnt0), .obi_rvalid_i(1'b0), .obi_rdata_i(rdata0));

  adam_debug_axil_obi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_TRANS(4),
                               .USE_RVALID(1'b1), .RD_LATENCY(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .pause_req_i(1'b0), .pause_ack_o(ack1),
    .axil_aw_addr_i(32'h0), .axil_aw_valid_i(1'b0), .axil_aw_ready_o(aw_ready1),
    .axil_w_data_i(32'h0), .axil_w_strb_i(4'h0), .axil_w_valid_i(1'b0), .axil_w_ready_o(w_ready1),
    .axil_b_resp_o(b_resp1), .axil_b_valid_o(b_valid1), .axil_b_ready_i(1'b1),
    .axil_ar_addr_i(ar_addr1), .axil_ar_valid_i(ar_valid1), .axil_ar_ready_o(ar_ready1),
    .axil_r_data_o(r_data1), .axil_r_resp_o(r_resp1), .axil_r_valid_o(r_valid1), .axil_r_ready_i(r_ready1),
    .obi_req_o(req1), .obi_we_o(we1), .obi_addr_o(addr1), .obi_be_o(be1), .obi_wdata_o(wdata1),
    .obi_gnt_i(gnt1), .obi_rvalid_i(rvalid1), .obi_rdata_i(rdata1));

  // read data pattern returned by the u0 memory model
  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // u0 OBI slave: read data valid the cycle after req&gnt
  always @(posedge clk)
    if (req0 && gnt0 && !we0) rdata0 <= f(addr0);

  // response order log for the interleave test
  logic [31:0] log_q[$];
  bit          log_en = 0;
  always begin
    @(negedge clk); #2;
    if (log_en) begin
      if (b_valid0 && b_ready0) log_q.push_back(32'hB0B0B0B0);
      if (r_valid0 && r_ready0) log_q.push_back(r_data0);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // wait (bounded) for an R beat on u0 and check its data; accepts it
  task automatic wait_r(input string tag, input logic [31:0] exp);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); r_ready0 = 1; #1;
      if (r_valid0) begin
        seen = 1;
        chk(tag, r_data0, exp);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  int hs;

  initial begin
    // reset state, with valids asserted
    @(negedge clk); aw_valid0 = 1; w_valid0 = 1; ar_valid0 = 1; #1;
    chk("rst_aw_ready", aw_ready0, 0);
    chk("rst_ar_ready", ar_ready0, 0);
    chk("rst_outs", {b_valid0, r_valid0, req0, ack0, addr0, r_data0}, 0);
    @(negedge clk); aw_valid0 = 0; w_valid0 = 0; ar_valid0 = 0; rst_n = 1;

    // 1: single write, fixed latency
    @(negedge clk); aw_valid0 = 1; w_valid0 = 1; aw_addr0 = 32'h1000; w_data0 = 32'hDEADBEEF; w_strb0 = 4'hF; #1;
    chk("t1_awready", {aw_ready0, w_ready0}, 2'b11);
    @(negedge clk); aw_valid0 = 0; w_valid0 = 0; #1;
    chk("t1_req", {req0, we0, be0}, {1'b1, 1'b1, 4'hF});
    chk("t1_addr", addr0, 32'h1000);
    chk("t1_wdata", wdata0, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("t1_n2", {req0, b_valid0}, 2'b00);
    @(negedge clk); #1;
    chk("t1_bvalid", {b_valid0, b_resp0}, 3'b100);
    @(negedge clk); #1;
    chk("t1_bdone", b_valid0, 0);

    // 2: read on u1, gnt delayed 3 cycles, rvalid 2 after gnt
    @(negedge clk); ar_valid1 = 1; ar_addr1 = 32'h1004; #1;
    chk("t2_arready", ar_ready1, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); ar_valid1 = 0; #1;
      chk("t2_hold_req", {req1, we1, be1, addr1}, {1'b1, 1'b0, 4'hF, 32'h1004});
      chk("t2_hold_wdata", wdata1, 0);
    end
    @(negedge clk); gnt1 = 1; #1;
    chk("t2_gnt_req", {req1, addr1}, {1'b1, 32'h1004});
    @(negedge clk); gnt1 = 0; #1;
    chk("t2_req_drop", req1, 0);
    @(negedge clk); rvalid1 = 1; rdata1 = 32'h12345678; #1;
    chk("t2_no_r_yet", r_valid1, 0);
    @(negedge clk); rvalid1 = 0; rdata1 = 0; #1;
    chk("t2_rvalid", {r_valid1, r_resp1}, 3'b100);
    chk("t2_rdata", r_data1, 32'h12345678);
    @(negedge clk); #1;
    chk("t2_rdone", r_valid1, 0);

    // 3: credit limit with r_ready low
    hs = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); r_ready0 = 0; ar_valid0 = 1; ar_addr0 = 32'h2000 + 32'(4 * hs); #1;
      if (ar_ready0) hs++;
    end
    chk("t3_handshakes", hs, 4);
    @(negedge clk); r_ready0 = 1; ar_addr0 = 32'h2010; #1;
    chk("t3_full_arready", ar_ready0, 0);
    chk("t3_head", {r_valid0, r_data0}, {1'b1, f(32'h2000)});
    @(negedge clk); r_ready0 = 0; #1;
    chk("t3_credit_back", ar_ready0, 1);
    @(negedge clk); ar_valid0 = 0;
    for (int k = 1; k < 5; k++) wait_r("t3_order", f(32'h2000 + 32'(4 * k)));

    // 4: write and read valid every cycle
    repeat (4) @(negedge clk);
    log_en = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      aw_valid0 = 1; w_valid0 = 1; aw_addr0 = 32'h3000 + 32'(4 * i); w_data0 = 32'(i);
      ar_valid0 = 1; ar_addr0 = 32'h3100 + 32'(4 * (i / 2)); #1;
      chk("t4_alternate", {aw_ready0, ar_ready0}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    @(negedge clk); aw_valid0 = 0; w_valid0 = 0; ar_valid0 = 0;
    repeat (8) @(negedge clk);
    log_en = 0;
    chk("t4_count", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      chk("t4_order", log_q[i], (i % 2 == 0) ? 32'hB0B0B0B0 : f(32'h3100 + 32'(4 * (i / 2))));

    // 5: pause with two in flight
    @(negedge clk); aw_valid0 = 1; w_valid0 = 1; aw_addr0 = 32'h4100; w_data0 = 32'h55; #1;
    chk("t5_wr_acc", aw_ready0, 1);
    @(negedge clk); aw_valid0 = 0; w_valid0 = 0; ar_valid0 = 1; ar_addr0 = 32'h4000; #1;
    chk("t5_rd_acc", ar_ready0, 1);
    @(negedge clk); pause0 = 1; aw_valid0 = 1; w_valid0 = 1; ar_addr0 = 32'h4004; #1;
    chk("t5_blocked", {aw_ready0, ar_ready0, ack0}, 3'b000);
    @(negedge clk); #1;
    chk("t5_b", {b_valid0, ar_ready0, ack0}, 3'b100);
    @(negedge clk); #1;
    chk("t5_r", {r_valid0, ack0, r_data0}, {2'b10, f(32'h4000)});
    @(negedge clk); #1;
    chk("t5_ack", {ack0, aw_ready0, ar_ready0}, 3'b100);
    @(negedge clk); #1;
    chk("t5_ack_hold", ack0, 1);
    @(negedge clk); pause0 = 0; aw_valid0 = 0; w_valid0 = 0; #1;
    chk("t5_resume", {ar_ready0, ack0}, 2'b11);
    @(negedge clk); ar_valid0 = 0; r_ready0 = 0; #1;
    chk("t5_ack_drop", ack0, 0);
    wait_r("t5_after", f(32'h4004));

    // 6: reset with three in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); r_ready0 = 0; ar_valid0 = 1; ar_addr0 = 32'h5100 + 32'(4 * k);
    end
    @(negedge clk); rst_n = 0; aw_valid0 = 1; w_valid0 = 1; #1;
    chk("t6_rst_ready", {aw_ready0, w_ready0, ar_ready0}, 3'b000);
    chk("t6_rst_outs", {r_valid0, b_valid0, req0, ack0, addr0, be0}, 0);
    @(negedge clk); aw_valid0 = 0; w_valid0 = 0; ar_valid0 = 0; rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("t6_no_stale", {r_valid0, b_valid0}, 2'b00);
    end
    @(negedge clk); ar_valid0 = 1; ar_addr0 = 32'h5000; #1;
    chk("t6_new_acc", ar_ready0, 1);
    @(negedge clk); ar_valid0 = 0;
    wait_r("t6_new_r", f(32'h5000));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
